fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter_if.sv | 35 +++
 rtl/fb_arbiter.sv | 113 +++++++++++
 tb/tb_fb_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_arbiter_if
// Brief    : Scanout, writer and single-port RAM signal bundle for fb_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface fb_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24
);
  logic              SCAN_REQ;
  logic [ADDR_W-1:0] SCAN_ADDR;
  logic [DATA_W-1:0] SCAN_DATA;
  logic              SCAN_VALID;
  logic              WR_VALID;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_READY;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic              RAM_WE;
  logic [DATA_W-1:0] RAM_WDATA;
  logic [DATA_W-1:0] RAM_RDATA;
  logic              SCAN_OVERRUN;

  modport master (
    output SCAN_REQ, SCAN_ADDR, WR_VALID, WR_ADDR, WR_DATA, RAM_RDATA,
    input  SCAN_DATA, SCAN_VALID, WR_READY, RAM_ADDR, RAM_WE, RAM_WDATA, SCAN_OVERRUN
  );

  modport slave (
    input  SCAN_REQ, SCAN_ADDR, WR_VALID, WR_ADDR, WR_DATA, RAM_RDATA,
    output SCAN_DATA, SCAN_VALID, WR_READY, RAM_ADDR, RAM_WE, RAM_WDATA, SCAN_OVERRUN
  );
endinterface
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_arbiter
// Brief    : Single-port framebuffer RAM arbiter between scanout reads and a
//            pixel writer, with a 1-entry scan pending slot and write anti-starvation.
// Revision : 1.0  initial release
// ============================================================================
module fb_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 24,
  parameter int MAX_WAIT = 4
) (
  input wire         CLOCK_50,
  input wire         RESET_N,
  fb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);

  logic              r_pend_v;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_overrun;
  logic [1:0]        r_rd_pipe;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_scan_valid;
  logic [DATA_W-1:0] r_scan_data;

  logic              w_scan_src;
  logic              w_force;
  logic              w_wr_grant;
  logic              w_scan_grant;
  logic [ADDR_W-1:0] w_scan_addr;

  always_comb begin
    w_scan_src   = r_pend_v | bus.SCAN_REQ;
    w_force      = (r_cnt == c_max_wait);
    w_wr_grant   = bus.WR_VALID & (~w_scan_src | w_force);
    w_scan_grant = w_scan_src & ~w_wr_grant;
    w_scan_addr  = r_pend_v ? r_pend_addr : bus.SCAN_ADDR;
  end

  // Gated by reset so the writer never sees a handshake while the block is held.
  assign bus.WR_READY     = RESET_N & w_wr_grant;
  assign bus.RAM_WE       = r_ram_we;
  assign bus.RAM_ADDR     = r_ram_addr;
  assign bus.RAM_WDATA    = r_ram_wdata;
  assign bus.SCAN_VALID   = r_scan_valid;
  assign bus.SCAN_DATA    = r_scan_data;
  assign bus.SCAN_OVERRUN = r_overrun;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_cnt       <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_wr_grant) begin
        if (!r_pend_v) begin
          r_pend_v    <= bus.SCAN_REQ;
          r_pend_addr <= bus.SCAN_ADDR;
        end else if (bus.SCAN_REQ) begin
          r_overrun <= 1'b1;
        end
      end else if (w_scan_grant && r_pend_v) begin
        // Pending slot is being served; the new request (if any) takes its place.
        r_pend_v    <= bus.SCAN_REQ;
        r_pend_addr <= bus.SCAN_ADDR;
      end

      if (!bus.WR_VALID || w_wr_grant) begin
        r_cnt <= '0;
      end else if (r_cnt != c_max_wait) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_we <= w_wr_grant;
      if (w_wr_grant) begin
        r_ram_addr  <= bus.WR_ADDR;
        r_ram_wdata <= bus.WR_DATA;
      end else if (w_scan_grant) begin
        r_ram_addr <= w_scan_addr;
      end
    end
  end

  // Stage 0: address out to RAM; stage 1: RAM data valid; then captured.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rd_pipe    <= 2'b00;
      r_scan_valid <= 1'b0;
      r_scan_data  <= '0;
    end else begin
      r_rd_pipe    <= {r_rd_pipe[0], w_scan_grant};
      r_scan_valid <= r_rd_pipe[1];
      if (r_rd_pipe[1]) begin
        r_scan_data <= bus.RAM_RDATA;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_arbiter
// Brief    : Self-checking bench for fb_arbiter with a queue-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_arbiter;
  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 24;
  localparam int MAX_WAIT = 4;
  localparam int MEM_N    = 1 << ADDR_W;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  logic [DATA_W-1:0] tb_mem  [MEM_N];
  logic [DATA_W-1:0] ref_mem [MEM_N];

  // Synchronous single-port RAM: read data one cycle after the address.
  always @(posedge CLOCK_50) begin
    if (bus.RAM_WE) tb_mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
    bus.RAM_RDATA <= tb_mem[bus.RAM_ADDR];
  end

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t sb[$];

  // Reference model: scans waiting for the RAM, write wait time, expected RAM command.
  logic [ADDR_W-1:0] m_q[$];
  int                m_wait;
  bit                m_ovr;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  bit                w_pend;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic post_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    w_pend = 1'b1;
    w_addr = a;
    w_data = d;
  endtask

  task automatic step(input bit sreq, input logic [ADDR_W-1:0] saddr);
    bit                exp_rdy;
    int                src;
    logic [ADDR_W-1:0] a;
    @(negedge CLOCK_50);
    chk("ram_we",    bus.RAM_WE,       m_we);
    chk("ram_addr",  bus.RAM_ADDR,     m_addr);
    chk("ram_wdata", bus.RAM_WDATA,    m_wdata);
    chk("overrun",   bus.SCAN_OVERRUN, m_ovr);
    bus.SCAN_REQ  = sreq;
    bus.SCAN_ADDR = sreq ? saddr : ADDR_W'($urandom);
    bus.WR_VALID  = w_pend;
    bus.WR_ADDR   = w_addr;
    bus.WR_DATA   = w_data;
    #1;
    src     = m_q.size() + (sreq ? 1 : 0);
    exp_rdy = w_pend && (src == 0 || m_wait == MAX_WAIT);
    chk("wr_ready", bus.WR_READY, exp_rdy);
    m_we = 1'b0;
    if (sreq) m_q.push_back(saddr);
    if (exp_rdy) begin
      ref_mem[w_addr] = w_data;
      m_we    = 1'b1;
      m_addr  = w_addr;
      m_wdata = w_data;
      m_wait  = 0;
      w_pend  = 1'b0;
      if (m_q.size() > 1) begin
        void'(m_q.pop_back());
        m_ovr = 1'b1;
      end
    end else begin
      if (m_q.size() > 0) begin
        a      = m_q.pop_front();
        m_addr = a;
        sb.push_back('{ref_mem[a], cyc + 3});
      end
      m_wait = w_pend ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_scan_valid", bus.SCAN_VALID,   0);
    chk("rst_scan_data",  bus.SCAN_DATA,    0);
    chk("rst_ram_we",     bus.RAM_WE,       0);
    chk("rst_ram_addr",   bus.RAM_ADDR,     0);
    chk("rst_ram_wdata",  bus.RAM_WDATA,    0);
    chk("rst_wr_ready",   bus.WR_READY,     0);
    chk("rst_overrun",    bus.SCAN_OVERRUN, 0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET_N       = 1'b0;
    bus.SCAN_REQ  = 1'b0;
    bus.WR_VALID  = 1'b1;
    bus.WR_ADDR   = ADDR_W'($urandom);
    bus.WR_DATA   = DATA_W'($urandom);
    #1;
    check_reset_outputs();
    m_q.delete();
    sb.delete();
    m_wait  = 0;
    m_ovr   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    w_pend  = 1'b0;
    @(negedge CLOCK_50);
    #1;
    check_reset_outputs();
    bus.WR_VALID = 1'b0;
    RESET_N      = 1'b1;
  endtask

  // Monitor: every SCAN_VALID pulse must match the oldest outstanding read, on time.
  initial begin
    exp_t              e;
    logic [DATA_W-1:0] last;
    last = '0;
    forever begin
      @(negedge CLOCK_50);
      #3;
      if (!RESET_N) begin
        last = '0;
      end else if (bus.SCAN_VALID) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scan_unexpected: got data 0x%0h expected no pulse at cycle %0d", bus.SCAN_DATA, cyc);
        end else begin
          e = sb.pop_front();
          chk("scan_data",    bus.SCAN_DATA, e.data);
          chk("scan_latency", cyc,           e.due);
        end
        last = bus.SCAN_DATA;
      end else begin
        chk("scan_hold", bus.SCAN_DATA, last);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL scan_missing: got no pulse expected data 0x%0h due cycle %0d", e.data, e.due);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int dens[3];
    dens = '{30, 70, 95};
    for (int i = 0; i < MEM_N; i++) begin
      tb_mem[i]  = DATA_W'((i * 32'h009E_3779) ^ 32'h0055_AA33);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[17'h10]  = 24'hAABBCC;
    ref_mem[17'h10] = 24'hAABBCC;
    bus.SCAN_REQ  = 1'b0;
    bus.SCAN_ADDR = '0;
    bus.WR_VALID  = 1'b0;
    bus.WR_ADDR   = '0;
    bus.WR_DATA   = '0;
    w_pend = 1'b0;
    w_addr = '0;
    w_data = '0;

    do_reset();

    // Lone scan, then lone write and read-back.
    step(1'b1, 17'h10);
    repeat (4) step(1'b0, '0);
    post_write(17'd5, 24'h123456);
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, 17'd5);
    repeat (4) step(1'b0, '0);

    // Starvation: scans every cycle, write forced on the fifth.
    post_write(17'h20, 24'h0F0F0F);
    for (int i = 0; i < 6; i++) step(1'b1, ADDR_W'(17'h40 + i));
    repeat (4) step(1'b0, '0);

    // Overrun: second forced write while pending is full and a scan arrives.
    post_write(17'h21, 24'h111111);
    for (int i = 0; i < 12; i++) begin
      if (i == 6) post_write(17'h22, 24'h222222);
      step(1'b1, ADDR_W'(17'h50 + i));
    end
    repeat (4) step(1'b0, '0);

    // Reset one cycle after a read is issued.
    step(1'b1, 17'h10);
    do_reset();
    step(1'b1, 17'h10);
    repeat (4) step(1'b0, '0);

    // Ordering across a forced write.
    post_write(17'h23, 24'h333333);
    step(1'b1, 17'd7);
    step(1'b1, 17'd8);
    step(1'b1, 17'd9);
    step(1'b1, 17'd1);
    step(1'b1, 17'd2);
    step(1'b1, 17'd3);
    repeat (4) step(1'b0, '0);

    // Randomized traffic over a small shared address window.
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      for (int i = 0; i < 1000; i++) begin
        if (!w_pend && $urandom_range(0, 3) == 0)
          post_write(ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
        step($urandom_range(0, 99) < dens[ph], ADDR_W'($urandom_range(0, 31)));
      end
      while (w_pend) step(1'b0, '0);
      repeat (6) step(1'b0, '0);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
